// File: rtl/zmod_pll_ctrl.sv
// Sequencing and supervision controller for a PLLE4_BASE and its BUFGCE-gated clocks.
// Handles PLL reset/power-down, LOCKED qualification, staggered clock enables and lock-loss recovery.
module zmod_pll_ctrl #(
  parameter int NUM_OUT       = 2,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int EN_SPACING    = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               pll_pwrdwn,
  output logic [NUM_OUT-1:0] clk_en,
  output logic               ready,
  output logic               fault,
  output logic [7:0]         retry_cnt,
  output logic [15:0]        lock_loss_cnt,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    ENABLE    = 3'd4,
    RUN       = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam logic [31:0]        RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0]        TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0]        STABLE_LAST = 32'(STABLE_CYCLES - 1);
  localparam logic [31:0]        SPACE_LAST  = 32'(EN_SPACING - 1);
  localparam logic [7:0]         RETRY_LIMIT = 8'(MAX_RETRY);
  localparam logic [NUM_OUT-1:0] EN_FIRST    = NUM_OUT'(1);

  state_t               state_q, state_n;
  logic [31:0]          cnt_q, cnt_n;
  logic [NUM_OUT-1:0]   clk_en_n;
  logic [7:0]           retry_n;
  logic [15:0]          loss_n;
  logic                 lock_meta, lock_sync;
  logic                 fail_attempt, lock_lost;

  assign state_dbg = state_q;

  // LOCKED is asynchronous to clk; two flops before anything looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q + 32'd1;
    clk_en_n     = clk_en;
    retry_n      = retry_cnt;
    loss_n       = lock_loss_cnt;
    fail_attempt = 1'b0;
    lock_lost    = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      retry_n = 8'd0;
    end else begin
      case (state_q)
        IDLE:      state_n = RESET;
        RESET:     if (cnt_q == RST_LAST) state_n = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_sync)                  state_n = STABLE;
          else if (cnt_q == TIMEOUT_LAST) fail_attempt = 1'b1;
        end
        STABLE: begin
          // A low sample wins over completion of the stable count.
          if (!lock_sync) fail_attempt = 1'b1;
          else if (cnt_q == STABLE_LAST) begin
            state_n  = ENABLE;
            clk_en_n = EN_FIRST;
          end
        end
        ENABLE: begin
          if (!lock_sync)   lock_lost = 1'b1;
          else if (&clk_en) state_n = RUN;
          else if (cnt_q == SPACE_LAST) begin
            clk_en_n = clk_en | (clk_en << 1);
            cnt_n    = 32'd0;
          end
        end
        RUN:     if (!lock_sync) lock_lost = 1'b1;
        FAULT:   state_n = FAULT;
        default: state_n = IDLE;
      endcase

      if (fail_attempt) begin
        retry_n = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
        state_n = ((MAX_RETRY != 0) && (retry_n == RETRY_LIMIT)) ? FAULT : RESET;
      end
      if (lock_lost) begin
        loss_n  = (lock_loss_cnt == 16'hFFFF) ? lock_loss_cnt : lock_loss_cnt + 16'd1;
        state_n = RESET;
      end
      if (state_n == RUN && state_q != RUN) retry_n = 8'd0;
    end

    if (state_n != state_q) cnt_n = 32'd0;
    if (state_n != ENABLE && state_n != RUN) clk_en_n = '0;
  end

  // Outputs are registered from the next state so they are valid on the first cycle of each state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 32'd0;
      clk_en        <= '0;
      retry_cnt     <= 8'd0;
      lock_loss_cnt <= 16'd0;
      pll_rst       <= 1'b1;
      pll_pwrdwn    <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      clk_en        <= clk_en_n;
      retry_cnt     <= retry_n;
      lock_loss_cnt <= loss_n;
      pll_rst       <= (state_n == IDLE) || (state_n == RESET) || (state_n == FAULT);
      pll_pwrdwn    <= (state_n == IDLE) || (state_n == FAULT);
      ready         <= (state_n == RUN);
      fault         <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_zmod_pll_ctrl.sv
// Directed bench for zmod_pll_ctrl: bring-up, timeout to fault, unstable lock, lock loss,
// mid-sequence disable and asynchronous reset, against a simple PLL lock model.
module tb_zmod_pll_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pll_locked;
  logic        pll_rst;
  logic        pll_pwrdwn;
  logic [1:0]  clk_en;
  logic        ready;
  logic        fault;
  logic [7:0]  retry_cnt;
  logic [15:0] lock_loss_cnt;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // PLL model: LOCKED rises 6 cycles after RST falls, with an optional one-cycle glitch.
  bit lock_auto    = 1'b1;
  bit glitch_armed = 1'b0;
  int rst_low_cnt  = 0;

  logic [31:0] exp_q[$];

  zmod_pll_ctrl #(
    .NUM_OUT(2), .RST_CYCLES(4), .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8), .EN_SPACING(3), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .pll_pwrdwn(pll_pwrdwn), .clk_en(clk_en),
    .ready(ready), .fault(fault), .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0d expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // Advance one clock, sample #1 after the edge, then update the PLL model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pll_rst) rst_low_cnt = 0;
    else         rst_low_cnt++;
    if (glitch_armed && rst_low_cnt == 12) begin
      pll_locked   = 1'b0;
      glitch_armed = 1'b0;
    end else begin
      pll_locked = lock_auto && (rst_low_cnt >= 6);
    end
    chk("inv_ready_implies_all_en", {31'd0, ready && (fault || clk_en != 2'b11)}, 32'd0);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!ready && n < budget) begin tick(); n++; end
    chk(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int w;
    rst        = 1'b1;
    enable     = 1'b0;
    pll_locked = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("rst_pwrdwn", {31'd0, pll_pwrdwn}, 32'd1);
    chk("rst_clk_en", {30'd0, clk_en}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_retry", {24'd0, retry_cnt}, 32'd0);
    chk("rst_loss", {16'd0, lock_loss_cnt}, 32'd0);

    // Nominal bring-up
    enable = 1'b1;
    sb_push(32'd4); sb_push(32'd3); sb_push(32'd1);
    w = 0;
    while (pll_pwrdwn && w < 10) begin tick(); w++; end
    chk("nom_reset_entered", {31'd0, pll_pwrdwn}, 32'd0);
    w = 0;
    while (pll_rst && w < 50) begin w++; tick(); end
    sb_check("nom_rst_width", w);
    w = 0;
    while (clk_en == 2'b00 && w < 100) begin tick(); w++; end
    chk("nom_first_en", {30'd0, clk_en}, 32'd1);
    w = 0;
    while (!clk_en[1] && w < 50) begin w++; tick(); end
    sb_check("nom_en_gap", w);
    chk("nom_both_en", {30'd0, clk_en}, 32'd3);
    w = 0;
    while (!ready && w < 50) begin w++; tick(); end
    sb_check("nom_ready_gap", w);
    chk("nom_retry", {24'd0, retry_cnt}, 32'd0);
    chk("nom_fault", {31'd0, fault}, 32'd0);

    // Lock loss in RUN
    tick();
    sb_push(32'd3);
    pll_locked = 1'b0;
    tick();
    w = 1;
    while (clk_en != 2'b00 && w < 10) begin tick(); w++; end
    sb_check("loss_edges_to_off", w);
    chk("loss_ready", {31'd0, ready}, 32'd0);
    chk("loss_cnt", {16'd0, lock_loss_cnt}, 32'd1);
    chk("loss_pll_rst", {31'd0, pll_rst}, 32'd1);
    wait_ready("loss_reready", 200);
    chk("loss_cnt_kept", {16'd0, lock_loss_cnt}, 32'd1);
    chk("loss_retry", {24'd0, retry_cnt}, 32'd0);

    // Disable mid-sequence
    enable = 1'b0;
    tick();
    chk("dis_idle_state", {29'd0, state_dbg}, 32'd0);
    enable = 1'b1;
    w = 0;
    while (clk_en == 2'b00 && w < 200) begin tick(); w++; end
    chk("dis_en01", {30'd0, clk_en}, 32'd1);
    enable = 1'b0;
    tick();
    chk("dis_clk_en", {30'd0, clk_en}, 32'd0);
    chk("dis_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("dis_pwrdwn", {31'd0, pll_pwrdwn}, 32'd1);
    chk("dis_loss_kept", {16'd0, lock_loss_cnt}, 32'd1);

    // Timeout retries to fault
    lock_auto  = 1'b0;
    pll_locked = 1'b0;
    tick();
    enable = 1'b1;
    sb_push(32'd4); sb_push(32'd20); sb_push(32'd4); sb_push(32'd20);
    w = 0;
    while (pll_pwrdwn && w < 10) begin tick(); w++; end
    w = 0;
    while (pll_rst && w < 50) begin w++; tick(); end
    sb_check("to_rst_width1", w);
    w = 0;
    while (!pll_rst && w < 100) begin w++; tick(); end
    sb_check("to_wait1", w);
    chk("to_retry1", {24'd0, retry_cnt}, 32'd1);
    chk("to_pwrdwn_in_reset", {31'd0, pll_pwrdwn}, 32'd0);
    w = 0;
    while (pll_rst && w < 50) begin w++; tick(); end
    sb_check("to_rst_width2", w);
    w = 0;
    while (!pll_rst && w < 100) begin w++; tick(); end
    sb_check("to_wait2", w);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_fault_pwrdwn", {31'd0, pll_pwrdwn}, 32'd1);
    chk("to_retry2", {24'd0, retry_cnt}, 32'd2);
    for (int i = 0; i < 5; i++) tick();
    chk("to_fault_held", {31'd0, fault}, 32'd1);
    enable = 1'b0;
    tick();
    chk("to_fault_clear", {31'd0, fault}, 32'd0);
    chk("to_retry_clear", {24'd0, retry_cnt}, 32'd0);

    // Unstable lock: one glitch during STABLE, then a clean attempt
    lock_auto    = 1'b1;
    glitch_armed = 1'b1;
    enable       = 1'b1;
    w = 0;
    while (retry_cnt != 8'd1 && w < 100) begin tick(); w++; end
    chk("unst_retry1", {24'd0, retry_cnt}, 32'd1);
    chk("unst_second_reset", {31'd0, pll_rst}, 32'd1);
    chk("unst_not_ready", {31'd0, ready}, 32'd0);
    wait_ready("unst_ready", 200);
    chk("unst_retry_cleared", {24'd0, retry_cnt}, 32'd0);

    // Async reset mid-STABLE
    enable = 1'b0;
    tick();
    enable = 1'b1;
    w = 0;
    while (state_dbg != 3'd3 && w < 200) begin tick(); w++; end
    chk("ar_in_stable", {29'd0, state_dbg}, 32'd3);
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("ar_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("ar_pwrdwn", {31'd0, pll_pwrdwn}, 32'd1);
    chk("ar_clk_en", {30'd0, clk_en}, 32'd0);
    chk("ar_ready", {31'd0, ready}, 32'd0);
    chk("ar_fault", {31'd0, fault}, 32'd0);
    chk("ar_retry", {24'd0, retry_cnt}, 32'd0);
    chk("ar_loss", {16'd0, lock_loss_cnt}, 32'd0);
    chk("ar_state", {29'd0, state_dbg}, 32'd0);
    tick();
    rst = 1'b0;
    enable = 1'b0;
    tick();

    chk("sb_drained", exp_q.size(), 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
